// File: rtl/len_cnt_pkg.sv
// Shared length-counter definitions: index width, index type and the 2A03 length table.
package len_cnt_pkg;

  localparam int LEN_IDX_W = 5;

  typedef logic [LEN_IDX_W-1:0] len_idx_t;

  localparam logic [7:0] LEN_TABLE [0:31] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

endpackage

// File: rtl/len_lut.sv
// Combinational length-table lookup, shared by every channel's length counter.
module len_lut
  import len_cnt_pkg::*;
(
  input  len_idx_t   idx_i,
  output logic [7:0] len_o
);

  always_comb begin
    len_o = LEN_TABLE[idx_i];
  end

endmodule

// File: rtl/apu_length_counter.sv
// 2A03 APU per-channel length counter with halt bit and channel-active gate.
// Optional debug freeze input and dropped-load flag under `LEN_CNT_DBG_EN.
module apu_length_counter
  import len_cnt_pkg::*;
#(
  parameter int   CNT_W    = 8,
  parameter logic HALT_RST = 1'b0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             ena,
  input  logic             ld,
  input  len_idx_t         ld_idx,
  input  logic             halt_wr,
  input  logic             halt_in,
  input  logic             hf_tick,
  output logic [CNT_W-1:0] cnt,
  output logic             active
`ifdef LEN_CNT_DBG_EN
  ,
  input  logic             dbg_frz,
  output logic             dbg_ld_drop
`endif
);

  // The table is 8 bits wide; a narrower counter would truncate it.
  if (CNT_W < 8) begin : g_cnt_w_chk
    $error("apu_length_counter: CNT_W must be at least 8");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q;
  logic [7:0]       lut_len;
  logic             frz;
  logic             eff;
  logic             drop_d;

  len_lut u_lut (
    .idx_i (ld_idx),
    .len_o (lut_len)
  );

`ifdef LEN_CNT_DBG_EN
  assign frz = dbg_frz;
`else
  assign frz = 1'b0;
`endif

  // A tick only counts when not halted (pre-edge halt) and the count is nonzero.
  assign eff = hf_tick && !halt_q && (cnt_q != '0) && !frz;

  always_comb begin
    cnt_d  = cnt_q;
    drop_d = 1'b0;
    if (!ena) begin
      cnt_d  = '0;
      drop_d = ld;
    end else if (eff) begin
      cnt_d  = cnt_q - CNT_W'(1);
      drop_d = ld;
    end else if (ld) begin
      cnt_d  = CNT_W'(lut_len);
    end else begin
      cnt_d  = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q  <= '0;
      halt_q <= HALT_RST;
    end else begin
      cnt_q <= cnt_d;
      if (halt_wr) begin
        halt_q <= halt_in;
      end
    end
  end

`ifdef LEN_CNT_DBG_EN
  logic drop_q;

  always_ff @(posedge clk) begin
    if (res) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign dbg_ld_drop = drop_q;
`endif

  assign cnt    = cnt_q;
  assign active = (cnt_q != '0);

endmodule

// File: tb/tb_apu_length_counter.sv
// Self-checking bench for apu_length_counter: directed vector table plus randomized run
// against a behavioural model. Debug-port checks are enabled with LEN_CNT_DBG_EN.
module tb_apu_length_counter;

  logic       clk = 1'b0;
  logic       res, ena, ld, halt_wr, halt_in, hf_tick;
  logic [4:0] ld_idx;
  logic [7:0] cnt;
  logic       active;
`ifdef LEN_CNT_DBG_EN
  logic       dbg_frz, dbg_ld_drop;
`endif

  always #5 clk = ~clk;

  apu_length_counter #(.CNT_W(8), .HALT_RST(1'b0)) dut (
    .clk     (clk),
    .res     (res),
    .ena     (ena),
    .ld      (ld),
    .ld_idx  (ld_idx),
    .halt_wr (halt_wr),
    .halt_in (halt_in),
    .hf_tick (hf_tick),
    .cnt     (cnt),
    .active  (active)
`ifdef LEN_CNT_DBG_EN
    ,
    .dbg_frz     (dbg_frz),
    .dbg_ld_drop (dbg_ld_drop)
`endif
  );

  typedef struct {
    bit       res;
    bit       ena;
    bit       ld;
    bit [4:0] idx;
    bit       hw;
    bit       hi;
    bit       tk;
    bit       frz;
    int       exp;
  } vec_t;

  int TBL [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                   12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  int   n_chk = 0;
  int   n_pass = 0;
  int   m_cnt = 0;
  bit   m_halt = 1'b0;
  bit   m_drop = 1'b0;
  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic vec_t mk(input bit r, input bit e, input bit l, input int idx,
                              input bit hw, input bit hi, input bit tk, input int exp);
    vec_t v;
    v.res = r; v.ena = e; v.ld = l; v.idx = 5'(idx);
    v.hw = hw; v.hi = hi; v.tk = tk; v.frz = 1'b0; v.exp = exp;
    return v;
  endfunction

  // Reference: the length counter's rules applied to integer state at one clock edge.
  task automatic model_edge(input vec_t v);
    bit eff;
    if (v.res) begin
      m_cnt  = 0;
      m_halt = 1'b0;
      m_drop = 1'b0;
    end else begin
      eff    = v.tk && !m_halt && (m_cnt > 0) && !v.frz;
      m_drop = v.ld && (!v.ena || eff);
      if (!v.ena)     m_cnt = 0;
      else if (eff)   m_cnt = m_cnt - 1;
      else if (v.ld)  m_cnt = TBL[v.idx];
      if (v.hw) m_halt = v.hi;
    end
  endtask

  task automatic step(input vec_t v);
    res = v.res; ena = v.ena; ld = v.ld; ld_idx = v.idx;
    halt_wr = v.hw; halt_in = v.hi; hf_tick = v.tk;
`ifdef LEN_CNT_DBG_EN
    dbg_frz = v.frz;
`endif
    @(posedge clk);
    model_edge(v);
    #1;
    if (v.exp >= 0) chk("vec_cnt", int'(cnt), v.exp);
    chk("model_cnt", int'(cnt), m_cnt);
    chk("active", int'(active), (m_cnt != 0) ? 1 : 0);
`ifdef LEN_CNT_DBG_EN
    chk("dbg_ld_drop", int'(dbg_ld_drop), int'(m_drop));
`endif
  endtask

  initial begin
    vec_t v;
    res = 1'b0; ena = 1'b0; ld = 1'b0; ld_idx = 5'd0;
    halt_wr = 1'b0; halt_in = 1'b0; hf_tick = 1'b0;
`ifdef LEN_CNT_DBG_EN
    dbg_frz = 1'b0;
`endif

    //             res ena ld idx hw hi tk exp
    vecs.push_back(mk(1, 1, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 3,  0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 0, 0, 10));
    vecs.push_back(mk(0, 1, 0, 0,  1, 1, 1, 9));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 9));
    vecs.push_back(mk(0, 1, 0, 0,  1, 0, 0, 9));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 8));
    vecs.push_back(mk(0, 1, 1, 7,  0, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 5));
    vecs.push_back(mk(0, 1, 1, 1,  0, 0, 1, 4));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1,  0, 0, 1, 254));
    vecs.push_back(mk(0, 1, 1, 6,  0, 0, 0, 80));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 5,  0, 0, 0, 4));
    vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2,  0, 0, 0, 20));
    vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 0, 0, 10));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 10));
    vecs.push_back(mk(0, 1, 0, 0,  1, 0, 0, 10));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 9));
    vecs.push_back(mk(0, 1, 1, 24, 0, 0, 0, 192));
    vecs.push_back(mk(0, 1, 1, 31, 0, 0, 0, 30));
`ifdef LEN_CNT_DBG_EN
    vecs.push_back(mk(0, 1, 1, 2,  0, 0, 0, 20));
    v = mk(0, 1, 0, 0, 0, 0, 1, 20); v.frz = 1'b1; vecs.push_back(v);
    v = mk(0, 1, 0, 0, 0, 0, 1, 20); v.frz = 1'b1; vecs.push_back(v);
    v = mk(0, 1, 1, 3, 0, 0, 1, 2);  v.frz = 1'b1; vecs.push_back(v);
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 4,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 0, 0, 10));
    vecs.push_back(mk(0, 1, 1, 0,  0, 0, 1, 9));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 9));
`endif

    foreach (vecs[i]) step(vecs[i]);

    // Randomized run: mostly enabled, frequent loads and ticks, occasional halt and reset.
    for (int i = 0; i < 600; i++) begin
      v.res = ($urandom_range(0, 49) == 0);
      v.ena = ($urandom_range(0, 7) != 0);
      v.ld  = ($urandom_range(0, 3) == 0);
      v.idx = 5'($urandom_range(0, 31));
      v.hw  = ($urandom_range(0, 5) == 0);
      v.hi  = ($urandom_range(0, 2) == 0);
      v.tk  = ($urandom_range(0, 2) == 0);
`ifdef LEN_CNT_DBG_EN
      v.frz = ($urandom_range(0, 9) == 0);
`else
      v.frz = 1'b0;
`endif
      v.exp = -1;
      step(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apu_length_counter.md
Name: apu_length_counter

Overview:
- Per-channel length counter for the 2A03 APU square, triangle and noise channels.
- Sits directly downstream of the register-file flip-flops (sdffr-based latches):
  - consumes the latched length index, halt bit and channel-enable bit;
  - produces the channel "active" gate that silences the channel when the count reaches zero.
- Decrements once per half-frame tick from the frame sequencer.

Parameters:
- CNT_W, 8, width of the length count.
- HALT_RST, 0, value of the halt register after reset.

Ports:
- clk     input   1      system clock; all state updates on its rising edge
- res     input   1      synchronous active-high reset
- ena     input   1      channel enable (status register bit); 0 forces count to 0
- ld      input   1      one-cycle write strobe to the length-load register
- ld_idx  input   5      length table index, sampled when ld=1
- halt_wr input   1      one-cycle write strobe for the halt bit
- halt_in input   1      new halt value, sampled when halt_wr=1
- hf_tick input   1      one-cycle half-frame clock from the frame sequencer
- cnt     output  CNT_W  current length count
- active  output  1      1 when cnt != 0, combinational from the cnt register

Behaviour:
- Decided: one clock, clk; reset is synchronous and active-high, res. Nothing else is asynchronous.
- Reset: while res=1 at an edge:
  - cnt <= 0, so active=0;
  - halt <= HALT_RST;
  - all other inputs are ignored.
- Priority per edge: res > ena=0 clear > tick/load rule.
- ena=0: cnt <= 0 each edge; ld is ignored, with no deferred load.
- Effective tick (eff) = hf_tick && !halt_q && (cnt != 0).
  - halt_q is the halt value before this edge.
  - A halt_wr in the same cycle affects the next tick only.
- Count update with ena=1:
  - eff=1: cnt <= cnt - 1. A coincident ld is dropped.
  - else ld=1: cnt <= LEN_TABLE[ld_idx], zero-extended to CNT_W.
  - else: cnt holds.
- Load latency: one edge. cnt shows the table value on the cycle after the ld strobe.
- Arithmetic and width rules:
  - Decrement never wraps; cnt=0 is a fixed point for ticks.
  - The table is 8 bits wide.
  - CNT_W < 8 is illegal; flag it with an elaboration-time error.
- Halt register: halt_q <= halt_in on halt_wr. Independent of ena, so it updates even while ena=0.
- active goes low in the same cycle cnt becomes 0. No extra register stage.
- Reset mid-count: cnt returns to 0 immediately on the reset edge. The next ld after res falls loads normally.

Optional Feature:
- Macro: LEN_CNT_DBG_EN.
- Defined:
  - adds input dbg_frz (1 bit): when 1, eff is forced to 0, freezing the count while loads still apply;
  - adds output dbg_ld_drop (1 bit): registered, pulses one cycle after an ld dropped by eff or by ena=0.
- Undefined: both ports are absent and the behaviour is exactly as above.

Decomposition:
- Package len_cnt_pkg:
  - LEN_IDX_W=5;
  - LEN_TABLE[0:31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30;
  - a typedef for the 5-bit index.
- Sub-module len_lut: combinational, ld_idx to 8-bit table value, shared with the other channels' instances.
- Counter and halt register stay in apu_length_counter.

Test Plan:
- Reset: res=1 for 2 cycles with ld=1, ld_idx=1, ena=1 -> cnt=0, active=0, halt=HALT_RST.
- Load and count down:
  - stimulus: ena=1, ld pulse with ld_idx=3 (table value 2), then hf_tick twice;
  - response: cnt=2 one cycle after ld, then 1, then 0, with active falling on the 0 cycle;
  - a third tick keeps cnt=0.
- Halt:
  - stimulus: load ld_idx=0 (cnt=10), halt_wr with halt_in=1 coincident with a tick, then another tick;
  - response: the coincident tick decrements to 9; the next tick leaves cnt=9.
- Load/tick collision:
  - cnt=5 with ld (ld_idx=1) and hf_tick in the same cycle -> cnt=4, load dropped;
  - cnt=0 with ld (ld_idx=1) and hf_tick in the same cycle -> cnt=254.
- Enable clear:
  - cnt=80, then ena=0 -> cnt=0 next edge;
  - ld (ld_idx=5) while ena=0 -> cnt stays 0;
  - after ena returns to 1, cnt stays 0 until a new ld.
- Debug build (LEN_CNT_DBG_EN):
  - dbg_frz=1 with ticks at cnt=20 -> cnt stays 20;
  - ld while ena=0 -> dbg_ld_drop=1 for exactly one cycle.
